// File: rtl/alu_unit_if.sv
// Operand/result bundle between the ezRISC operand muxes and the execute-stage ALU.
// The master drives the operation select and operands; the slave returns the
// registered result and its status flags.
interface alu_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output alu_ctrl,
        output a,
        output b,
        input  result,
        input  zero,
        input  carry,
        input  overflow
    );

    modport slave (
        input  alu_ctrl,
        input  a,
        input  b,
        output result,
        output zero,
        output carry,
        output overflow
    );
endinterface

// File: rtl/alu_unit.sv
// 32-bit integer ALU for the ezRISC execute stage.
// Twelve operations selected by a 4-bit code; result, carry and overflow are
// registered (one-cycle latency), zero is decoded from the result register.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_unit_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOR   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_SLT   = 4'h9;
    localparam logic [3:0] OP_SLTU  = 4'hA;
    localparam logic [3:0] OP_PASSB = 4'hB;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SHW-1:0]   shamt_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             overflow_s;

    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;

    // Shared adder/subtractor; subtraction is a + ~b + 1 so its carry-out means "no borrow".
    always_comb begin
        sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
        diff_s    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        shamt_s   = bus.b[SHW-1:0];
        add_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
        sub_ovf_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
    end

    // Operation select; only ADD/SUB produce carry and overflow, reserved codes yield zero.
    always_comb begin
        result_s   = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        overflow_s = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD: begin
                result_s   = sum_s[WIDTH-1:0];
                carry_s    = sum_s[WIDTH];
                overflow_s = add_ovf_s;
            end
            OP_SUB: begin
                result_s   = diff_s[WIDTH-1:0];
                carry_s    = diff_s[WIDTH];
                overflow_s = sub_ovf_s;
            end
            OP_AND:   result_s = bus.a & bus.b;
            OP_OR:    result_s = bus.a | bus.b;
            OP_XOR:   result_s = bus.a ^ bus.b;
            OP_NOR:   result_s = ~(bus.a | bus.b);
            OP_SLL:   result_s = bus.a << shamt_s;
            OP_SRL:   result_s = bus.a >> shamt_s;
            OP_SRA:   result_s = $unsigned($signed(bus.a) >>> shamt_s);
            OP_SLT: begin
                if ($signed(bus.a) < $signed(bus.b)) begin
                    result_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    result_s = {WIDTH{1'b0}};
                end
            end
            OP_SLTU: begin
                if (bus.a < bus.b) begin
                    result_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    result_s = {WIDTH{1'b0}};
                end
            end
            OP_PASSB: result_s = bus.b;
            default: begin
                result_s   = {WIDTH{1'b0}};
                carry_s    = 1'b0;
                overflow_s = 1'b0;
            end
        endcase
    end

    // Output register; reset wins over whatever operation is presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r   <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            result_r   <= result_s;
            carry_r    <= carry_s;
            overflow_r <= overflow_s;
        end
    end

    assign bus.result   = result_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = (result_r == {WIDTH{1'b0}});
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit with a queue-based scoreboard.
// Stimulus is applied on the falling edge and pushes the hand-computed response;
// the monitor pops one entry per rising edge (sampled 1 time unit later).
module tb_alu_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        zero;
        logic        carry;
        logic        overflow;
    } exp_t;

    exp_t sb_q[$];

    alu_unit_if #(.WIDTH(32)) bus ();

    alu_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
        end
    endtask

    // Monitor: the DUT presents a new response after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check1(e.name, "result",   bus.result,          e.result);
                check1(e.name, "zero",     {31'd0, bus.zero},     {31'd0, e.zero});
                check1(e.name, "carry",    {31'd0, bus.carry},    {31'd0, e.carry});
                check1(e.name, "overflow", {31'd0, bus.overflow}, {31'd0, e.overflow});
            end
        end
    end

    task automatic drive(input string nm, input logic r, input logic [3:0] c,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic ec, input logic eo);
        exp_t e;
        rst          = r;
        bus.alu_ctrl = c;
        bus.a        = av;
        bus.b        = bv;
        e.name       = nm;
        e.result     = er;
        e.zero       = (er == 32'd0);
        e.carry      = ec;
        e.overflow   = eo;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.alu_ctrl = 4'h0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        @(negedge clk);

        // Reset with arbitrary inputs, then first ADD
        drive("reset",     1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        drive("add_b5_0d", 1'b0, 4'h0, 32'h0000_00B5, 32'h0000_000D, 32'h0000_00C2, 1'b0, 1'b0);

        // Opcode sweep
        drive("sub",   1'b0, 4'h1, 32'h0000_00B5, 32'h0000_000D, 32'h0000_00A8, 1'b1, 1'b0);
        drive("and",   1'b0, 4'h2, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0005, 1'b0, 1'b0);
        drive("or",    1'b0, 4'h3, 32'h0000_00B5, 32'h0000_000D, 32'h0000_00BD, 1'b0, 1'b0);
        drive("xor",   1'b0, 4'h4, 32'h0000_00B5, 32'h0000_000D, 32'h0000_00B8, 1'b0, 1'b0);
        drive("nor",   1'b0, 4'h5, 32'h0000_00B5, 32'h0000_000D, 32'hFFFF_FF42, 1'b0, 1'b0);
        drive("sll",   1'b0, 4'h6, 32'h0000_00B5, 32'h0000_000D, 32'h0016_A000, 1'b0, 1'b0);
        drive("srl",   1'b0, 4'h7, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);
        drive("sra",   1'b0, 4'h8, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);
        drive("slt",   1'b0, 4'h9, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);
        drive("sltu",  1'b0, 4'hA, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);
        drive("passb", 1'b0, 4'hB, 32'h0000_00B5, 32'h0000_000D, 32'h0000_000D, 1'b0, 1'b0);

        // All-ones operands
        drive("add_ones", 1'b0, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        drive("sub_ones", 1'b0, 4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        drive("sra_ones", 1'b0, 4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive("sll_ones", 1'b0, 4'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        drive("slt_ones", 1'b0, 4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);

        // Signed boundaries
        drive("add_ovf",  1'b0, 4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        drive("sub_ovf",  1'b0, 4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        drive("slt_neg",  1'b0, 4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        drive("sltu_neg", 1'b0, 4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        drive("sub_borrow", 1'b0, 4'h1, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Shift masking and shift by zero
        drive("sll_mask",  1'b0, 4'h6, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0);
        drive("sra_zero",  1'b0, 4'h8, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 1'b0, 1'b0);
        drive("srl_sign",  1'b0, 4'h7, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0);
        drive("sra_sign",  1'b0, 4'h8, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0);

        // Reserved codes, preceded by a flag-setting ADD so stale flags would show
        drive("add_pre",  1'b0, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        drive("rsvd_c",   1'b0, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        drive("rsvd_d",   1'b0, 4'hD, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);
        drive("rsvd_e",   1'b0, 4'hE, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);
        drive("rsvd_f",   1'b0, 4'hF, 32'h0000_00B5, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b0);

        // Reset mid-stream has priority, then the held ADD completes
        drive("add_pre2", 1'b0, 4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        drive("rst_mid",  1'b1, 4'h0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0000, 1'b0, 1'b0);
        drive("add_post", 1'b0, 4'h0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() != 0) begin
                @(negedge clk);
            end
        end
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the ezRISC datapath; sits in the execute stage between the operand muxes and the writeback/branch logic.
- Performs one of 12 operations selected by a 4-bit control code.
- Result and status flags are registered: one-cycle latency, single clock domain.

Parameters:
- WIDTH, 32, operand/result width in bits. Shift-amount width is log2(WIDTH), i.e. 5 for the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_ctrl  input  4  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- result  output  WIDTH  registered operation result.
- zero  output  1  high when result is all zeros.
- carry  output  1  registered carry-out (ADD/SUB only).
- overflow  output  1  registered signed overflow (ADD/SUB only).

Behaviour:
- Reset: on a rising clk edge with rst=1: result=0, carry=0, overflow=0.
- zero is combinational from the result register, so it reads 1 during and after reset.
- rst has priority over any operation on the same edge.
- Latency: inputs sampled at rising edge N; result and flags valid after edge N; updated every cycle. There is no enable and no handshake.
- Opcodes (a, b unsigned unless noted):
  - 0x0 ADD: a+b. carry = bit WIDTH of the sum. overflow = operands have the same sign and the result sign differs.
  - 0x1 SUB: a-b, computed as a+~b+1. carry = carry-out of that sum, so 1 means no borrow (a>=b unsigned). overflow = operands have different signs and the result sign differs from a.
  - 0x2 AND: a&b.
  - 0x3 OR: a|b.
  - 0x4 XOR: a^b.
  - 0x5 NOR: ~(a|b).
  - 0x6 SLL: a << b[4:0].
  - 0x7 SRL: logical right shift a >> b[4:0], zero fill.
  - 0x8 SRA: arithmetic right shift of a by b[4:0], sign fill.
  - 0x9 SLT: 1 if signed(a) < signed(b), else 0 (zero-extended).
  - 0xA SLTU: 1 if a < b unsigned, else 0.
  - 0xB PASSB: result = b (LUI / immediate move).
  - 0xC–0xF: reserved; result = 0.
- carry and overflow are 0 for every opcode except ADD/SUB.
- Shifts use only b[4:0]; upper bits of b are ignored. A shift by 0 returns a unchanged.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- X/undefined alu_ctrl is not supported; behaviour is only specified for defined 4-bit values.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> result=0x00000000, zero=1, carry=0, overflow=0. Release rst, a=0xB5, b=0x0D, ctrl=0x0 -> after next edge result=0x000000C2, carry=0, overflow=0, zero=0.
- Sweep ctrl 0x1..0xB with a=0x000000B5, b=0x0000000D, one opcode per cycle -> results one cycle later:
  - SUB 0x000000A8 (carry=1)
  - AND 0x00000005
  - OR 0x000000BD
  - XOR 0x000000B8
  - NOR 0xFFFFFF42
  - SLL 0x0016A000
  - SRL 0x00000000 (zero=1)
  - SRA 0x00000000
  - SLT 0
  - SLTU 0
  - PASSB 0x0000000D
- All-ones operands, a=b=0xFFFFFFFF:
  - ADD -> 0xFFFFFFFE, carry=1, overflow=0.
  - SUB -> 0x00000000, zero=1, carry=1, overflow=0.
  - SRA -> 0xFFFFFFFF.
  - SLL -> 0x80000000 (shift 31).
  - SLT -> 0.
- Signed boundaries:
  - ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1, carry=0.
  - SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow=1.
  - SLT a=0xFFFFFFFF, b=1 -> 1; SLTU on the same operands -> 0.
- Shift masking: a=0x00000001, b=0x00000021 with SLL -> 0x00000002 (only b[4:0]=1 used). Reserved ctrl 0xC..0xF -> result 0, flags 0.
- Reset mid-stream: drive ADD with a=0x10, b=0x20, assert rst on the same edge -> result=0. Deassert rst -> next edge result=0x30.
